// File: rtl/sync_edge_event.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sync_edge_event                                                   |
// | Glitch-filters a synchronized level, timestamps its transitions and queues |
// | them in a show-ahead FIFO. Macro SYNC_EVT_FALL_EN also queues falling edges.|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module sync_edge_event #(
  parameter int FILT_CYCLES = 2,
  parameter int TS_W        = 16,
  parameter int DEPTH       = 4
) (
  input  logic            clk_b,
  input  logic            rst,
  input  logic            sig_b,
  output logic            level,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic            evt_rise,
  output logic [TS_W-1:0] evt_ts,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         OCC_W     = PTR_W + 1;
  localparam logic [7:0] FILT_LAST = 8'(FILT_CYCLES - 1);
`ifdef SYNC_EVT_FALL_EN
  localparam bit         FALL_EN   = 1'b1;
`else
  localparam bit         FALL_EN   = 1'b0;
`endif

  logic             level_q, level_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic [TS_W-1:0]  ts_q;
  logic [TS_W:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             head_rise_q, head_rise_d;
  logic [TS_W-1:0]  head_ts_q, head_ts_d;
  logic             evt_gen, push_req, push, pop, full, ovf_evt;

  // Glitch filter: level follows sig_b only after FILT_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    fcnt_d  = fcnt_q;
    evt_gen = 1'b0;
    if (sig_b == level_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FILT_LAST) begin
      level_d = sig_b;
      fcnt_d  = '0;
      evt_gen = 1'b1;
    end else begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  assign evt_valid = (occ_q != '0);
  assign full      = (occ_q == OCC_W'(DEPTH));
  assign pop       = evt_valid && evt_ready;
  assign push_req  = evt_gen && (sig_b || FALL_EN);
  assign ovf_evt   = push_req && full && !pop;
  assign push      = push_req && !ovf_evt;
  assign rd_nxt    = rd_ptr_q + PTR_W'(1);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    ovf_d = ovf_evt ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // Head registers hold the last shown entry once the FIFO drains.
  always_comb begin
    head_rise_d = head_rise_q;
    head_ts_d   = head_ts_q;
    if (push && ((occ_q == '0) || ((occ_q == OCC_W'(1)) && pop))) begin
      head_rise_d = sig_b;
      head_ts_d   = ts_q;
    end else if (pop && (occ_q > OCC_W'(1))) begin
      {head_rise_d, head_ts_d} = mem_q[rd_nxt];
    end
`ifndef SYNC_EVT_FALL_EN
    head_rise_d = 1'b1;
`endif
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      level_q     <= 1'b0;
      fcnt_q      <= '0;
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      ovf_q       <= 1'b0;
      head_rise_q <= 1'b0;
      head_ts_q   <= '0;
    end else begin
      level_q     <= level_d;
      fcnt_q      <= fcnt_d;
      ts_q        <= ts_q + TS_W'(1);
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      ovf_q       <= ovf_d;
      head_rise_q <= head_rise_d;
      head_ts_q   <= head_ts_d;
    end
  end

  always_ff @(posedge clk_b) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {sig_b, ts_q};
    end
  end

  assign level    = level_q;
  assign evt_rise = head_rise_q;
  assign evt_ts   = head_ts_q;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire
